// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t  : converter FSM states
//   BCD_NINE : digit value used to saturate the result on overflow
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Single BCD digit correction for the shift-add-3 algorithm.
//   din  : current 4-bit digit
//   dout : din + 3 when din >= 5, otherwise din unchanged
module bin2bcd_seq_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-add-3), one iteration per clock.
// Ports:
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_bin is the unsigned value
//   out_valid/out_ready   : output handshake for bcd/ovf/blank
//   bcd                   : packed BCD, digit 0 in bcd[3:0]
//   ovf                   : value above 10^DIGITS-1, bcd saturated to all 9s
//   blank                 : per-digit leading-zero mask (digit 0 never blanked)
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [BIN_W-1:0] bin_sr;
    logic [BW-1:0]   bcd_acc;
    logic [BW-1:0]   acc_adj;
    logic [BW-1:0]   acc_nx;
    logic            ovf_sticky;
    logic            ovf_nx;
    logic            last;

    function automatic logic [BW-1:0] sat_bcd(input logic [BW-1:0] acc, input logic ov);
        return ov ? {DIGITS{BCD_NINE}} : acc;
    endfunction

    // Walk from the top digit down; a digit is blank while everything above
    // it (and itself) is zero. Digit 0 always stays visible.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] acc, input logic ov);
        logic [DIGITS-1:0] m;
        logic              zero_run;
        m        = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (acc[4*i +: 4] == 4'd0);
            m[i]     = zero_run && !ov;
        end
        return m;
    endfunction

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bin2bcd_seq_digit_adj u_adj (
                .din  (bcd_acc[4*g +: 4]),
                .dout (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // The bit leaving the top digit after correction means the value no longer
    // fits in DIGITS digits; it is folded into the sticky overflow flag.
    assign acc_nx = {acc_adj[BW-2:0], bin_sr[BIN_W-1]};
    assign ovf_nx = ovf_sticky | acc_adj[BW-1];
    assign last   = (cnt == CW'(BIN_W - 1));

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (in_valid)  state_nx = ST_SHIFT;
            ST_SHIFT: if (last)      state_nx = ST_DONE;
            ST_DONE:  if (out_ready) state_nx = ST_IDLE;
            default:                 state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bin_sr     <= '0;
            bcd_acc    <= '0;
            ovf_sticky <= 1'b0;
            bcd        <= '0;
            ovf        <= 1'b0;
            blank      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        bin_sr     <= in_bin;
                        bcd_acc    <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= '0;
                    end
                end
                ST_SHIFT: begin
                    bin_sr     <= bin_sr << 1;
                    bcd_acc    <= acc_nx;
                    ovf_sticky <= ovf_nx;
                    cnt        <= cnt + 1'b1;
                    if (last) begin
                        bcd   <= sat_bcd(acc_nx, ovf_nx);
                        ovf   <= ovf_nx;
                        blank <= blank_mask(acc_nx, ovf_nx);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  iv = '0;
    logic [2:0]  ordy = 3'b111;
    logic [2:0]  ir, ovd, ovf_o;
    logic [15:0] bin [3];
    logic [11:0] bcd_a, bcd_b;
    logic [19:0] bcd_c;
    logic [2:0]  blank_a, blank_b;
    logic [4:0]  blank_c;
    logic [19:0] bcdw [3];
    logic [4:0]  blankw [3];

    int   nchk = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   bw [3] = '{8, 10, 16};
    int   dg [3] = '{3, 3, 5};
    exp_t q [3][$];
    int   acc_cyc [3];
    bit   vprev [3];
    logic [19:0] hold [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_bin(bin[0][7:0]),
        .out_valid(ovd[0]), .out_ready(ordy[0]), .bcd(bcd_a), .ovf(ovf_o[0]), .blank(blank_a));

    bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_bin(bin[1][9:0]),
        .out_valid(ovd[1]), .out_ready(ordy[1]), .bcd(bcd_b), .ovf(ovf_o[1]), .blank(blank_b));

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_bin(bin[2]),
        .out_valid(ovd[2]), .out_ready(ordy[2]), .bcd(bcd_c), .ovf(ovf_o[2]), .blank(blank_c));

    always_comb begin
        bcdw[0]   = {8'b0, bcd_a};
        bcdw[1]   = {8'b0, bcd_b};
        bcdw[2]   = bcd_c;
        blankw[0] = {2'b0, blank_a};
        blankw[1] = {2'b0, blank_b};
        blankw[2] = blank_c;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain decimal digit extraction.
    function automatic exp_t ref_conv(input int val, input int digits);
        exp_t e;
        int   lim = 1;
        int   v;
        int   p;
        e.bcd = '0;
        e.blank = '0;
        for (int i = 0; i < digits; i++) lim *= 10;
        e.ovf = (val >= lim);
        if (e.ovf) begin
            for (int i = 0; i < digits; i++) e.bcd[4*i +: 4] = 4'd9;
        end else begin
            v = val;
            for (int i = 0; i < digits; i++) begin
                e.bcd[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
            p = 10;
            for (int i = 1; i < digits; i++) begin
                e.blank[i] = (val < p);
                p *= 10;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                vprev[k]   = 1'b0;
                acc_cyc[k] = -1000;
            end else begin
                if (iv[k] && ir[k]) acc_cyc[k] = cyc + 1;
                if (ovd[k] && !vprev[k]) begin
                    if (q[k].size() == 0) begin
                        check($sformatf("u%0d_unexpected_out", k), ovd[k], 0);
                    end else begin
                        exp_t e;
                        e = q[k].pop_front();
                        check($sformatf("u%0d_bcd", k), bcdw[k], e.bcd);
                        check($sformatf("u%0d_ovf", k), ovf_o[k], e.ovf);
                        check($sformatf("u%0d_blank", k), blankw[k], e.blank);
                        check($sformatf("u%0d_latency", k), cyc - acc_cyc[k], bw[k]);
                    end
                    hold[k] = bcdw[k];
                end else if (ovd[k] && vprev[k]) begin
                    check($sformatf("u%0d_bcd_stable", k), bcdw[k], hold[k]);
                end
                vprev[k] = ovd[k];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input int val);
        int n = 0;
        while (!ir[k] && n < 200) begin
            tick();
            n++;
        end
        if (!ir[k]) check($sformatf("u%0d_ready_timeout", k), ir[k], 1);
        bin[k] = 16'(val);
        iv[k]  = 1'b1;
        q[k].push_back(ref_conv(val, dg[k]));
        tick();
        iv[k]  = 1'b0;
    endtask

    task automatic drain(input int k);
        int n = 0;
        while (q[k].size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check($sformatf("u%0d_drain_pending", k), q[k].size(), 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) bin[k] = '0;
        repeat (3) tick();
        check("rst_in_ready", ir[0], 1);
        check("rst_out_valid", ovd[0], 0);
        check("rst_bcd", bcd_a, 0);
        check("rst_ovf", ovf_o[0], 0);
        check("rst_blank", blank_a, 0);
        rst_n = 1'b1;
        tick();

        // basic values with fixed expectations
        send(0, 123);
        drain(0);
        check("v123_bcd", bcd_a, 12'h123);
        check("v123_blank", blank_a, 3'b000);
        send(0, 0);
        drain(0);
        check("v0_blank", blank_a, 3'b110);
        send(0, 7);
        drain(0);
        check("v7_bcd", bcd_a, 12'h007);
        check("v7_blank", blank_a, 3'b110);
        send(0, 255);
        drain(0);
        check("v255_bcd", bcd_a, 12'h255);

        // exhaustive 8-bit sweep, back to back
        for (int v = 0; v < 256; v++) send(0, v);
        drain(0);

        // backpressure: result must hold, no accept while DONE
        ordy[0] = 1'b0;
        send(0, 200);
        begin
            int n = 0;
            while (!ovd[0] && n < 50) begin
                tick();
                n++;
            end
        end
        check("bp_out_valid", ovd[0], 1);
        iv[0]  = 1'b1;
        bin[0] = 16'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready_low", ir[0], 0);
            check("bp_bcd_hold", bcd_a, 12'h200);
        end
        ordy[0] = 1'b1;
        iv[0]   = 1'b0;
        tick();
        check("bp_in_ready_after", ir[0], 1);
        check("bp_out_valid_after", ovd[0], 0);
        repeat (12) tick();
        check("bp_no_ghost", q[0].size(), 0);

        // 10-bit input into 3 digits: overflow boundaries
        send(1, 1023);
        drain(1);
        check("w10_1023_bcd", bcd_b, 12'h999);
        check("w10_1023_ovf", ovf_o[1], 1);
        check("w10_1023_blank", blank_b, 3'b000);
        send(1, 999);
        drain(1);
        check("w10_999_ovf", ovf_o[1], 0);
        send(1, 1000);
        send(1, 0);
        send(1, 512);
        send(1, 5);
        drain(1);

        // reset in the middle of a conversion
        send(0, 150);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", ovd[0], 0);
        check("mid_rst_in_ready", ir[0], 1);
        check("mid_rst_bcd", bcd_a, 0);
        q[0].delete();
        tick();
        rst_n = 1'b1;
        tick();
        send(0, 42);
        drain(0);
        check("after_rst_bcd", bcd_a, 12'h042);
        check("after_rst_blank", blank_a, 3'b100);

        // 16-bit / 5-digit: boundaries plus random sample
        begin
            int vals [12] = '{0, 1, 9, 10, 99, 100, 9999, 10000, 12345, 59999, 65534, 65535};
            for (int i = 0; i < 12; i++) send(2, vals[i]);
        end
        for (int i = 0; i < 60; i++) send(2, int'($urandom_range(0, 65535)));
        drain(2);
        check("w16_ovf_final", ovf_o[2], 0);

        for (int k = 0; k < 3; k++) drain(k);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
